// File: rtl/pc_sequencer_pkg.sv
// Shared fetch-control definitions: FSM encoding, PC reset vector, PC control polarities.
// Pure declarations, no logic.
package pc_sequencer_pkg;

  localparam int CPU_ADDR_W = 18;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MEM_ACC = 1'b1
  } state_e;

  localparam logic [CPU_ADDR_W-1:0] PC_RESET = 18'h08000;

  // PC register controls are active-low
  localparam logic PC_WR_EN = 1'b0;
  localparam logic PC_HOLD  = 1'b1;
  localparam logic PC_JMP   = 1'b0;
  localparam logic PC_INC   = 1'b1;

endpackage

// File: rtl/pc_sequencer_if.sv
// Pipeline-side event inputs and PC/pipeline control outputs of the fetch sequencer.
// master = pipeline (drives events), slave = sequencer (drives controls).
interface pc_sequencer_if #(
  parameter int ADDR_W = 18
) ();

  logic              hold;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              lu_hazard;
  logic              mem_req;

  logic              pc_write;
  logic              pc_jump;
  logic [ADDR_W-1:0] pc_jump_val;
  logic              mem_grant;
  logic              pipe_stall;
  logic              if_id_stall;
  logic              if_id_flush;
  logic              id_ex_flush;

  modport master (
    output hold, br_taken, br_target, lu_hazard, mem_req,
    input  pc_write, pc_jump, pc_jump_val, mem_grant, pipe_stall,
           if_id_stall, if_id_flush, id_ex_flush
  );

  modport slave (
    input  hold, br_taken, br_target, lu_hazard, mem_req,
    output pc_write, pc_jump, pc_jump_val, mem_grant, pipe_stall,
           if_id_stall, if_id_flush, id_ex_flush
  );

endinterface

// File: rtl/pc_sequencer_redirect_buf.sv
// Holds a taken-branch target that arrived while the PC was not writable.
// Capture wins over release; a newer capture overwrites the held target.
module pc_redirect_buf #(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture_i,
  input  logic [ADDR_W-1:0] tgt_i,
  input  logic              release_i,
  output logic              pend_v_o,
  output logic [ADDR_W-1:0] pend_tgt_o
);

  logic              pend_v_q,   pend_v_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

  always_comb begin
    pend_v_d   = pend_v_q;
    pend_tgt_d = pend_tgt_q;
    if (capture_i) begin
      pend_v_d   = 1'b1;
      pend_tgt_d = tgt_i;
    end else if (release_i) begin
      pend_v_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_v_q   <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      pend_v_q   <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pend_v_o   = pend_v_q;
  assign pend_tgt_o = pend_tgt_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch control: PC enable/redirect, shared SRAM arbitration, stall/flush resolution.
// All controls combinational from state and inputs; priority hold > MEM > branch > load-use.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W     = 18,
  parameter int MEM_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  localparam logic [3:0] CNT_LOAD = (MEM_CYCLES > 1) ? 4'(MEM_CYCLES - 2) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q,   cnt_d;

  logic              pend_v;
  logic [ADDR_W-1:0] pend_tgt;
  logic              capture, release_pend;

  logic              pc_write, pc_jump, mem_grant, pipe_stall;
  logic              if_id_stall, if_id_flush, id_ex_flush;
  logic [ADDR_W-1:0] pc_jump_val;

  pc_redirect_buf #(.ADDR_W(ADDR_W)) u_redirect_buf (
    .clk        (clk),
    .rst        (rst),
    .capture_i  (capture),
    .tgt_i      (bus.br_target),
    .release_i  (release_pend),
    .pend_v_o   (pend_v),
    .pend_tgt_o (pend_tgt)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = PC_HOLD;
    pc_jump      = PC_INC;
    pc_jump_val  = '0;
    mem_grant    = 1'b0;
    pipe_stall   = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    capture      = 1'b0;
    release_pend = 1'b0;

    if (!rst) begin
      // defaults already describe the reset outputs
    end else if (bus.hold) begin
      pipe_stall = 1'b1;
      capture    = bus.br_taken;
    end else if (state_q == ST_MEM_ACC) begin
      mem_grant = 1'b1;
      capture   = bus.br_taken;
      if (cnt_q != 4'd0) begin
        pipe_stall = 1'b1;
        cnt_d      = cnt_q - 4'd1;
      end else begin
        if_id_flush = 1'b1;
        state_d     = ST_RUN;
      end
    end else if (bus.mem_req) begin
      // SRAM taken by MEM this cycle, so nothing was fetched
      mem_grant   = 1'b1;
      if_id_flush = 1'b1;
      capture     = bus.br_taken;
      if (MEM_CYCLES > 1) begin
        pipe_stall = 1'b1;
        state_d    = ST_MEM_ACC;
        cnt_d      = CNT_LOAD;
      end
    end else if (bus.br_taken || pend_v) begin
      pc_write     = PC_WR_EN;
      pc_jump      = PC_JMP;
      pc_jump_val  = pend_v ? pend_tgt : bus.br_target;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      release_pend = 1'b1;
    end else if (bus.lu_hazard) begin
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      pc_write = PC_WR_EN;
    end

    // Wrong-path fetch behind a deferred branch is squashed unless the pipe is frozen
    if (capture && !pipe_stall) begin
      if_id_flush = 1'b1;
    end
    if (if_id_flush) begin
      if_id_stall = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.pc_jump     = pc_jump;
  assign bus.pc_jump_val = pc_jump_val;
  assign bus.mem_grant   = mem_grant;
  assign bus.pipe_stall  = pipe_stall;
  assign bus.if_id_stall = if_id_stall;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench: two sequencers (MEM_CYCLES=2 and 3) share one stimulus stream.
// Expected controls are queued per stimulus cycle and checked on the falling edge.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hold = 1'b0, br_taken = 1'b0, lu_hazard = 1'b0, mem_req = 1'b0;
  logic [17:0] br_target = 18'h3ABCD;

  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(18)) if2 ();
  pc_sequencer_if #(.ADDR_W(18)) if3 ();

  assign if2.hold = hold;  assign if2.br_taken = br_taken;  assign if2.br_target = br_target;
  assign if2.lu_hazard = lu_hazard;  assign if2.mem_req = mem_req;
  assign if3.hold = hold;  assign if3.br_taken = br_taken;  assign if3.br_target = br_target;
  assign if3.lu_hazard = lu_hazard;  assign if3.mem_req = mem_req;

  pc_sequencer #(.ADDR_W(18), .MEM_CYCLES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  pc_sequencer #(.ADDR_W(18), .MEM_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  // {pc_write, pc_jump, mem_grant, pipe_stall, if_id_stall, if_id_flush, id_ex_flush, pc_jump_val}
  logic [24:0] act2, act3;
  assign act2 = {if2.pc_write, if2.pc_jump, if2.mem_grant, if2.pipe_stall, if2.if_id_stall,
                 if2.if_id_flush, if2.id_ex_flush, if2.pc_jump_val};
  assign act3 = {if3.pc_write, if3.pc_jump, if3.mem_grant, if3.pipe_stall, if3.if_id_stall,
                 if3.if_id_flush, if3.id_ex_flush, if3.pc_jump_val};

  localparam logic [17:0] G     = 18'h3ABCD;
  localparam logic [24:0] IDLE  = {7'b0100000, 18'h0};
  localparam logic [24:0] RSTV  = {7'b1100000, 18'h0};
  localparam logic [24:0] MEM0  = {7'b1111010, 18'h0};
  localparam logic [24:0] MEMS  = {7'b1111000, 18'h0};
  localparam logic [24:0] MEMF  = {7'b1110010, 18'h0};
  localparam logic [24:0] HOLDV = {7'b1101000, 18'h0};
  localparam logic [24:0] LU    = {7'b1100101, 18'h0};

  function automatic logic [24:0] redir(input logic [17:0] t);
    return {7'b0000011, t};
  endfunction

  typedef struct {
    string       name;
    logic        sel;
    logic [24:0] vec;
    logic        chk_val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic step(input logic r, input logic h, input logic b, input logic [17:0] t,
                      input logic l, input logic m);
    @(posedge clk);
    #1;
    rst = r; hold = h; br_taken = b; br_target = t; lu_hazard = l; mem_req = m;
  endtask

  // Target bits are only meaningful during a redirect or in reset
  task automatic chk(input string n, input logic s, input logic [24:0] v, input logic force_val);
    exp_t e;
    e.name = n; e.sel = s; e.vec = v; e.chk_val = force_val || (v[23] == 1'b0);
    exp_q.push_back(e);
  endtask

  task automatic chkb(input string n, input logic [24:0] v, input logic force_val);
    chk({n, "_m2"}, 1'b0, v, force_val);
    chk({n, "_m3"}, 1'b1, v, force_val);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() != 0) begin
        exp_t        e;
        logic [24:0] a, mask;
        e    = exp_q.pop_front();
        a    = e.sel ? act3 : act2;
        mask = e.chk_val ? 25'h1FFFFFF : {7'h7F, 18'h0};
        n_checks++;
        if ((a & mask) !== (e.vec & mask)) begin
          n_err++;
          $display("FAIL %s: got %07h expected %07h (mask %07h) at %0t", e.name, a, e.vec, mask, $time);
        end
      end
    end
  end

  initial begin
    step(0, 0, 0, G, 0, 0);             chkb("reset", RSTV, 1);
    step(1, 0, 0, G, 0, 0);             chkb("rel", IDLE, 0);

    // reset in the middle of an access, with a deferred branch held
    step(1, 0, 1, 18'h08777, 0, 1);     chkb("rmid_c0", MEM0, 0);
    step(0, 0, 0, G, 0, 1);             chkb("rmid_rst", RSTV, 1);
    step(0, 0, 0, G, 0, 0);             chkb("rmid_rst2", RSTV, 1);
    step(1, 0, 0, G, 0, 0);             chkb("rmid_rel0", IDLE, 0);
    step(1, 0, 0, G, 0, 0);             chkb("rmid_rel1", IDLE, 0);
    step(1, 0, 0, G, 0, 0);             chkb("rmid_rel2", IDLE, 0);

    step(1, 0, 1, 18'h08123, 0, 0);     chkb("br", redir(18'h08123), 0);
    step(1, 0, 0, G, 0, 0);             chkb("br_after", IDLE, 0);

    step(1, 0, 0, G, 0, 1);             chkb("mem_c0", MEM0, 0);
    step(1, 0, 0, G, 0, 1);             chk("mem_c1_m2", 0, MEMF, 0); chk("mem_c1_m3", 1, MEMS, 0);
    step(1, 0, 0, G, 0, 0);             chk("mem_c2_m2", 0, IDLE, 0); chk("mem_c2_m3", 1, MEMF, 0);
    step(1, 0, 0, G, 0, 0);             chkb("mem_c3", IDLE, 0);

    step(1, 0, 1, 18'h08040, 0, 1);     chkb("pend_c0", MEM0, 0);
    step(1, 0, 0, G, 0, 1);             chk("pend_c1_m2", 0, MEMF, 0); chk("pend_c1_m3", 1, MEMS, 0);
    step(1, 0, 0, G, 0, 0);             chk("pend_apply_m2", 0, redir(18'h08040), 0);
                                        chk("pend_c2_m3", 1, MEMF, 0);
    step(1, 0, 0, G, 0, 0);             chk("pend_clr_m2", 0, IDLE, 0);
                                        chk("pend_apply_m3", 1, redir(18'h08040), 0);
    step(1, 0, 0, G, 0, 0);             chkb("pend_clr", IDLE, 0);

    step(1, 0, 0, G, 1, 0);             chkb("lu", LU, 0);
    step(1, 0, 0, G, 0, 0);             chkb("lu_after", IDLE, 0);
    step(1, 0, 1, 18'h08200, 1, 0);     chkb("lu_br", redir(18'h08200), 0);
    step(1, 0, 0, G, 0, 0);             chkb("lu_br_after", IDLE, 0);

    step(1, 0, 0, G, 1, 1);             chkb("mlu_c0", MEM0, 0);
    step(1, 0, 0, G, 1, 1);             chk("mlu_c1_m2", 0, MEMF, 0); chk("mlu_c1_m3", 1, MEMS, 0);
    step(1, 0, 0, G, 1, 0);             chk("mlu_c2_m2", 0, LU, 0);   chk("mlu_c2_m3", 1, MEMF, 0);
    step(1, 0, 0, G, 1, 0);             chkb("mlu_c3", LU, 0);
    step(1, 0, 0, G, 0, 0);             chkb("mlu_after", IDLE, 0);

    // hold freezes the access (m3 sits at cnt=1) and captures a branch without flushing
    step(1, 0, 0, G, 0, 1);             chkb("hold_c0", MEM0, 0);
    step(1, 1, 0, G, 0, 1);             chkb("hold_h1", HOLDV, 0);
    step(1, 1, 1, 18'h08300, 0, 1);     chkb("hold_h2", HOLDV, 0);
    step(1, 1, 0, G, 0, 1);             chkb("hold_h3", HOLDV, 0);
    step(1, 0, 0, G, 0, 1);             chk("hold_fin1_m3", 1, MEMS, 0); chk("hold_fin_m2", 0, MEMF, 0);
    step(1, 0, 0, G, 0, 0);             chk("hold_fin2_m3", 1, MEMF, 0);
                                        chk("hold_redir_m2", 0, redir(18'h08300), 0);
    step(1, 0, 0, G, 0, 0);             chk("hold_redir_m3", 1, redir(18'h08300), 0);
                                        chk("hold_idle_m2", 0, IDLE, 0);
    step(1, 0, 0, G, 0, 0);             chkb("hold_end", IDLE, 0);

    @(negedge clk);
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Central fetch-control block for the 5-stage pipeline.
- Drives the PC register's write-enable and jump controls (both active-low), and the 18-bit jump target.
- Arbitrates the shared instruction/data SRAM between IF and the MEM stage.
- Resolves simultaneous branch, load-use, structural and external-hold events into the stall, flush and bubble signals for the IF/ID and ID/EX registers.

Parameters:
- ADDR_W, 18, PC/target width.
- MEM_CYCLES, 2, cycles one MEM-stage SRAM access occupies the bus (legal 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- hold  in  1  external freeze (serial/IO wait), active-high
- br_taken  in  1  EX resolved branch/jump taken, active-high, single-cycle pulse
- br_target  in  ADDR_W  branch target, valid with br_taken
- lu_hazard  in  1  ID detects load-use dependency on EX load
- mem_req  in  1  MEM stage needs the shared SRAM, held until access done
- pc_write  out  1  0 = PC may update, 1 = PC holds
- pc_jump  out  1  0 = load pc_jump_val, 1 = PC+1
- pc_jump_val  out  ADDR_W  redirect target
- mem_grant  out  1  SRAM owned by MEM stage this cycle
- pipe_stall  out  1  freeze all pipeline registers
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_flush  out  1  load NOP into ID/EX

Behaviour:
- States: RUN, MEM_ACC. Registers: state, cnt[3:0], pend_v, pend_tgt.
- Outputs are combinational from state and inputs.
- While rst low:
  - state=RUN, cnt=0, pend_v=0, pend_tgt=0.
  - Outputs: pc_write=1, pc_jump=1, pc_jump_val=0; every other output 0.
  - Reset mid-access aborts the access: no grant after reset.
- Priority each cycle: hold > MEM access > branch > load-use > normal.
- hold=1:
  - pc_write=1 and pipe_stall=1.
  - state, cnt and pend frozen.
  - A br_taken arriving during hold is captured into pend (see branch rules). No other output asserted.
- RUN, no events: pc_write=0, pc_jump=1.
- RUN with mem_req:
  - mem_grant=1, pc_write=1, if_id_flush=1 (no fetch happened this cycle).
  - If MEM_CYCLES>1: pipe_stall=1, go to MEM_ACC with cnt=MEM_CYCLES-2.
  - If MEM_CYCLES==1: stay in RUN.
- MEM_ACC:
  - mem_grant=1, pc_write=1.
  - While cnt!=0: pipe_stall=1 and cnt decrements.
  - When cnt==0: pipe_stall=0, if_id_flush=1, return to RUN.
- Branch (br_taken, or pend_v) when the PC is writable this cycle (RUN, no mem_req, no hold):
  - pc_write=0, pc_jump=0, pc_jump_val = pend_v ? pend_tgt : br_target.
  - if_id_flush=1, id_ex_flush=1. Clear pend_v.
- br_taken when the PC is not writable: latch pend_tgt=br_target, pend_v=1.
  - Applied on the first writable cycle; a later br_taken overwrites pend.
  - Also flush IF/ID in the capture cycle unless pipe_stall is asserted.
- Load-use (lu_hazard, no branch, PC writable):
  - pc_write=1, if_id_stall=1, id_ex_flush=1 for that cycle only.
- Branch with lu_hazard in the same cycle: branch wins and lu_hazard is ignored, since the ID instruction is squashed.
- mem_req with lu_hazard: MEM access wins; lu_hazard is re-evaluated on return to RUN.
- if_id_stall and if_id_flush are never both 1; flush wins.
- No arithmetic on the PC here; the target passes through unmodified at full ADDR_W.

Decomposition:
- Shared cpu package holds:
  - state encoding (ST_RUN, ST_MEM_ACC)
  - PC_RESET = 18'h08000
  - active-low polarity constants PC_WR_EN=0, PC_JMP=0
- Single sub-module pc_redirect_buf (pend_v/pend_tgt capture-and-release register), unit-testable alone. The FSM and counter stay in the top level.

Test Plan:
- Reset low mid-MEM_ACC (cnt=1): outputs go immediately to pc_write=1, mem_grant=0. After release with no inputs, pc_write=0, pc_jump=1 every cycle.
- br_taken=1, br_target=18'h0_8123 in RUN: same cycle pc_jump=0, pc_jump_val=18'h08123, if_id_flush=1, id_ex_flush=1, pc_write=0.
- mem_req held 2 cycles, MEM_CYCLES=2:
  - cycle0: mem_grant=1, pipe_stall=1, pc_write=1.
  - cycle1: mem_grant=1, pipe_stall=0, if_id_flush=1.
  - cycle2: RUN, pc_write=0.
- br_taken with target 18'h08040 during cycle0 of a MEM access: pend captured. The first RUN cycle after the access shows pc_jump=0, pc_jump_val=18'h08040, then pend_v=0.
- lu_hazard=1 alone: one cycle of pc_write=1, if_id_stall=1, id_ex_flush=1. With br_taken in the same cycle: redirect only, if_id_stall=0.
- hold=1 for 3 cycles during MEM_ACC with cnt=1: cnt stays 1 and pipe_stall=1 throughout. After hold drops, the access finishes in exactly 2 more cycles.
